// File: rtl/dffe_share_arb.sv
// Round-robin owner of one shared enabled storage cell, with a bounded hold
// so a busy requester cannot lock the others out.

module dffe_share_arb_lane #(
  parameter int WIDTH = 1
) (
  input  logic             i_gnt,
  input  logic             i_req,
  input  logic [WIDTH-1:0] i_wdata,
  output logic             o_wr,
  output logic [WIDTH-1:0] o_data
);
  assign o_wr   = i_gnt & i_req;
  assign o_data = o_wr ? i_wdata : '0;
endmodule

module dffe_share_arb #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   wdata,
  output logic [NREQ-1:0]         gnt,
  output logic                    stor_en,
  output logic [WIDTH-1:0]        stor_din,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    busy
);
  localparam int IW = $clog2(NREQ);
  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef enum logic {S_IDLE, S_OWN} state_t;

  state_t                      r_state, w_state_nxt;
  logic [NREQ-1:0]             r_gnt, w_gnt_nxt;
  logic [IW-1:0]               r_ptr, w_ptr_nxt;
  logic [HW-1:0]               r_hcnt, w_hcnt_nxt;
  logic [IW-1:0]               r_owner;
  logic [IW-1:0]               w_k, w_k_inc;
  logic [NREQ-1:0]             w_others;
  logic [NREQ-1:0]             w_wr;
  logic [NREQ-1:0][WIDTH-1:0]  w_ldata;
  logic [WIDTH-1:0]            w_din;

  // First set bit of m scanning p, p+1, ... modulo NREQ; zero if m is empty.
  function automatic logic [NREQ-1:0] f_scan(input logic [NREQ-1:0] m,
                                             input logic [IW-1:0]   p);
    logic [NREQ-1:0] g;
    logic [IW-1:0]   idx;
    g = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      idx = IW'((int'(p) + j) % NREQ);
      if (m[idx]) begin
        g      = '0;
        g[idx] = 1'b1;
      end
    end
    return g;
  endfunction

  always_comb begin
    w_k = '0;
    for (int i = 0; i < NREQ; i++)
      if (r_gnt[i]) w_k = IW'(i);
  end

  assign w_k_inc  = (w_k == IW'(NREQ - 1)) ? '0 : w_k + 1'b1;
  assign w_others = req & ~r_gnt;

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_ptr_nxt   = r_ptr;
    w_hcnt_nxt  = r_hcnt;
    case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_gnt_nxt   = f_scan(req, r_ptr);
          w_hcnt_nxt  = HW'(1);
          w_state_nxt = S_OWN;
        end
      end
      S_OWN: begin
        if (!(|(r_gnt & req))) begin
          // Owner let go: hand straight to the next waiter, or fall idle.
          w_ptr_nxt = w_k_inc;
          w_gnt_nxt = f_scan(req, w_k_inc);
          if (|req) begin
            w_hcnt_nxt = HW'(1);
          end else begin
            w_hcnt_nxt  = '0;
            w_state_nxt = S_IDLE;
          end
        end else if ((|w_others) && (r_hcnt == HW'(MAX_HOLD))) begin
          w_ptr_nxt  = w_k_inc;
          w_gnt_nxt  = f_scan(w_others, w_k_inc);
          w_hcnt_nxt = HW'(1);
        end else if (r_hcnt < HW'(MAX_HOLD)) begin
          w_hcnt_nxt = r_hcnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_ptr   <= '0;
      r_hcnt  <= '0;
      r_owner <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_ptr   <= w_ptr_nxt;
      r_hcnt  <= w_hcnt_nxt;
      if (stor_en) r_owner <= w_k;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_lane
      dffe_share_arb_lane #(.WIDTH(WIDTH)) u_lane (
        .i_gnt   (r_gnt[gi]),
        .i_req   (req[gi]),
        .i_wdata (wdata[gi*WIDTH +: WIDTH]),
        .o_wr    (w_wr[gi]),
        .o_data  (w_ldata[gi])
      );
    end
  endgenerate

  // Grant is one-hot, so OR-ing the masked lanes selects the owner's data.
  always_comb begin
    w_din = '0;
    for (int i = 0; i < NREQ; i++) w_din = w_din | w_ldata[i];
  end

  assign stor_en  = |w_wr;
  assign stor_din = w_din;
  assign gnt      = r_gnt;
  assign owner    = r_owner;
  assign busy     = |r_gnt;
endmodule

// File: tb/tb_dffe_share_arb.sv
// Bench for dffe_share_arb: directed scenarios plus random traffic checked
// against an index-level round-robin model, with a behavioural storage cell.

module tb_dffe_share_arb;
  localparam int NREQ     = 4;
  localparam int WIDTH    = 4;
  localparam int MAX_HOLD = 3;
  localparam int IW       = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       gnt;
  logic                  stor_en;
  logic [WIDTH-1:0]      stor_din;
  logic [IW-1:0]         owner;
  logic                  busy;
  logic [WIDTH-1:0]      cell_q = '0;

  int n_chk = 0;
  int n_err = 0;

  // model state: granted index (-1 = none), pointer, hold count, owner, cell
  int m_g, m_ptr, m_hcnt, m_own;
  logic [WIDTH-1:0] m_cell = '0;

  always #5 clk = ~clk;

  dffe_share_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .wdata(wdata), .gnt(gnt),
    .stor_en(stor_en), .stor_din(stor_din), .owner(owner), .busy(busy)
  );

  always @(posedge clk) if (stor_en) cell_q <= stor_din;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic bit has(input logic [NREQ-1:0] v, input int i);
    return ((v >> i) & 1) != 0;
  endfunction

  // first requester at or after start (mod NREQ), skipping excl; -1 if none
  function automatic int scan(input logic [NREQ-1:0] v, input int start, input int excl);
    for (int j = 0; j < NREQ; j++) begin
      int idx;
      idx = (start + j) % NREQ;
      if (has(v, idx) && idx != excl) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_g = -1; m_ptr = 0; m_hcnt = 0; m_own = 0;
  endtask

  task automatic step(input logic r, input logic [NREQ-1:0] rq, input logic [NREQ*WIDTH-1:0] wd);
    logic [NREQ-1:0]  e_gnt;
    bit               e_en;
    logic [WIDTH-1:0] e_din;
    int               n, nxt;
    @(negedge clk);
    rst = r; req = rq; wdata = wd;
    #1;
    e_gnt = (m_g >= 0) ? NREQ'(1 << m_g) : '0;
    e_en  = (m_g >= 0) && has(rq, m_g);
    e_din = e_en ? WIDTH'(wd >> (m_g * WIDTH)) : '0;
    chk("gnt", 32'(gnt), 32'(e_gnt));
    chk("busy", 32'(busy), 32'(m_g >= 0));
    chk("stor_en", 32'(stor_en), 32'(e_en));
    chk("stor_din", 32'(stor_din), 32'(e_din));
    chk("owner", 32'(owner), 32'(m_own));
    chk("cell", 32'(cell_q), 32'(m_cell));
    if (e_en) m_cell = e_din;
    if (r) begin
      model_reset();
    end else begin
      if (e_en) m_own = m_g;
      if (m_g < 0) begin
        n = scan(rq, m_ptr, -1);
        if (n >= 0) begin m_g = n; m_hcnt = 1; end
      end else begin
        nxt = (m_g + 1) % NREQ;
        n   = scan(rq, nxt, m_g);
        if (!has(rq, m_g)) begin
          m_ptr = nxt; m_g = n; m_hcnt = (n >= 0) ? 1 : 0;
        end else if (n >= 0 && m_hcnt == MAX_HOLD) begin
          m_ptr = nxt; m_g = n; m_hcnt = 1;
        end else begin
          m_hcnt = (m_hcnt + 1 > MAX_HOLD) ? MAX_HOLD : m_hcnt + 1;
        end
      end
    end
  endtask

  initial begin
    logic [NREQ*WIDTH-1:0] wd;
    logic [NREQ-1:0]       rq;
    rst = 1'b1; req = '0; wdata = '0;
    repeat (2) @(posedge clk);
    model_reset();

    // reset state
    step(1, '0, '0);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_owner", 32'(owner), 0);
    chk("rst_busy", 32'(busy), 0);

    // lone request from idle: one cycle to first write, then the cell follows
    wd = 16'h0001;
    step(0, 4'b0001, wd);
    step(0, 4'b0001, wd);
    chk("tp1_gnt", 32'(gnt), 32'b0001);
    chk("tp1_en", 32'(stor_en), 1);
    chk("tp1_din", 32'(stor_din), 1);
    step(0, 4'b0000, wd);
    chk("tp1_owner", 32'(owner), 0);
    chk("tp1_cell", 32'(cell_q), 1);

    // simultaneous 1010: 1 wins, holds MAX_HOLD writes, then 3
    step(1, '0, '0);
    wd = 16'h9A5C;
    step(0, 4'b1010, wd);
    step(0, 4'b1010, wd);
    chk("tp2_first", 32'(gnt), 32'b0010);
    step(0, 4'b1010, wd);
    chk("tp2_hold2", 32'(gnt), 32'b0010);
    step(0, 4'b1010, wd);
    chk("tp2_hold3", 32'(gnt), 32'b0010);
    step(0, 4'b1010, wd);
    chk("tp2_rot", 32'(gnt), 32'b1000);

    // lone requester 2 never rotates
    step(1, '0, '0);
    step(0, 4'b0100, wd);
    for (int c = 0; c < 10; c++) begin
      step(0, 4'b0100, 16'($urandom));
      chk("tp3_gnt", 32'(gnt), 32'b0100);
      chk("tp3_en", 32'(stor_en), 1);
    end

    // owner 2 drops with 0 pending: wrap-around hand-off
    step(1, '0, '0);
    step(0, 4'b0100, wd);
    step(0, 4'b0101, wd);
    step(0, 4'b0001, wd);
    chk("tp4_drop_en", 32'(stor_en), 0);
    step(0, 4'b0001, wd);
    chk("tp4_gnt", 32'(gnt), 32'b0001);

    // reset while 3 owns and all request
    step(1, '0, '0);
    step(0, 4'b1000, wd);
    step(0, 4'b1000, wd);
    step(1, 4'b1111, wd);
    chk("tp5_pre", 32'(gnt), 32'b1000);
    step(0, 4'b1111, wd);
    chk("tp5_gnt", 32'(gnt), 0);
    chk("tp5_en", 32'(stor_en), 0);
    chk("tp5_owner", 32'(owner), 0);
    step(0, 4'b1111, wd);
    chk("tp5_regrant", 32'(gnt), 32'b0001);

    // one-cycle req gap by the owner releases to idle
    step(1, '0, '0);
    step(0, 4'b0010, wd);
    step(0, 4'b0010, wd);
    step(0, 4'b0000, wd);
    chk("tp6_en", 32'(stor_en), 0);
    step(0, 4'b0010, wd);
    chk("tp6_gnt", 32'(gnt), 0);
    chk("tp6_owner", 32'(owner), 1);
    step(0, 4'b0010, wd);
    chk("tp6_regrant", 32'(gnt), 32'b0010);

    // random traffic
    for (int c = 0; c < 600; c++) begin
      rq = '0;
      for (int b = 0; b < NREQ; b++)
        if ($urandom_range(0, 99) < 55) rq[b] = 1'b1;
      if ($urandom_range(0, 9) == 0) rq = NREQ'(1 << $urandom_range(0, NREQ - 1));
      step($urandom_range(0, 49) == 0, rq, 16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
